bram18_port_master: RTL

- Initiator-side controller for a single-port 1Kx18 synchronous block RAM: 16 data bits plus 2 parity bits, 1-cycle read latency, synchronous write.
- Merges an independent write-request channel and a read-request channel onto the one RAM port.
- Returns read data on a valid/ready response channel, using a credit-limited response FIFO so a RAM read is never lost.
- Sits between PicoBlaze-side loader/debug logic and the program/data BRAM.

---
 rtl/bram18_pkg.sv | 30 +++
 rtl/bram18_rsp_fifo.sv | 58 +++++
 rtl/bram18_port_master.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bram18_pkg.sv
// Shared widths, word type, grant encoding and byte-parity helper for the BRAM18 port master.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package bram18_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int PAR_W  = 2;
  localparam int WORD_W = DATA_W + PAR_W;

  // One RAM word as stored: {parity, data}
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WR,
    GNT_RD
  } grant_e;

  // Per-byte reduction XOR: bit i covers data byte i
  function automatic logic [PAR_W-1:0] byte_parity(input logic [DATA_W-1:0] d);
    logic [PAR_W-1:0] p;
    p = '0;
    for (int i = 0; i < PAR_W; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/bram18_rsp_fifo.sv
// Synchronous response FIFO holding captured RAM read words, in order.
// Latency: a word pushed at a clock edge is visible at the head in the next cycle.
// Backpressure: none internally; the caller's credit scheme keeps push away from a full FIFO.
module bram18_rsp_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_dat,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  import bram18_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // At full, a same-cycle pop frees the head slot that the push then reuses
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/bram18_port_master.sv
// Merges write and read request channels onto one 1Kx18 BRAM port; reads return via a response FIFO.
// Latency: write lands at the accept edge; read accept to RSP_VALID is 2 cycles.
// Backpressure: reads are admitted only with a free response credit; writes never stall except for arbitration.
// Build option: define BRAM18_PORT_MASTER_PARITY_EN to generate byte parity on writes and flag read parity errors on PAR_ERR.
module bram18_port_master #(
  parameter int ADDR_W    = bram18_pkg::ADDR_W,
  parameter int DATA_W    = bram18_pkg::DATA_W,
  parameter int PAR_W     = bram18_pkg::PAR_W,
  parameter int RSP_DEPTH = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WR_VALID,
  output logic                    WR_READY,
  input  logic [ADDR_W-1:0]       WR_ADDR,
  input  logic [DATA_W+PAR_W-1:0] WR_DATA,
  input  logic                    RD_VALID,
  output logic                    RD_READY,
  input  logic [ADDR_W-1:0]       RD_ADDR,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic [DATA_W+PAR_W-1:0] RSP_DATA,
  output logic [ADDR_W-1:0]       RAM_ADDR,
  output logic [DATA_W-1:0]       RAM_DI,
  output logic [PAR_W-1:0]        RAM_DIP,
  output logic                    RAM_EN,
  output logic                    RAM_WE,
  output logic                    RAM_SSR,
`ifdef BRAM18_PORT_MASTER_PARITY_EN
  output logic                    PAR_ERR,
`endif
  input  logic [DATA_W-1:0]       RAM_DO,
  input  logic [PAR_W-1:0]        RAM_DOP
);
  import bram18_pkg::*;

  localparam int WORD_W = DATA_W + PAR_W;
  localparam int FCNT_W = $clog2(RSP_DEPTH + 1);
  localparam int CNT_W  = FCNT_W + 1;

  grant_e            gnt;
  grant_e            last_grant;
  logic              rd_inflight;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;
  logic [CNT_W-1:0]  credit_cnt;
  logic              rd_ok;
  logic              wr_elig;
  logic              rd_elig;
  logic [WORD_W-1:0] cap_dat;
  logic [PAR_W-1:0]  wr_dip;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] di_q, di_nxt;
  logic [PAR_W-1:0]  dip_q, dip_nxt;

  // Credit: an outstanding read and every queued word each hold one FIFO slot;
  // a pop in this cycle frees its slot in time for a new read
  assign pop        = ~fifo_empty & RSP_READY;
  assign push       = rd_inflight;
  assign credit_cnt = CNT_W'(fifo_count) + CNT_W'(rd_inflight);
  assign rd_ok      = (credit_cnt - CNT_W'(pop)) < CNT_W'(RSP_DEPTH);

  // Nothing is granted while reset is held
  assign wr_elig = WR_VALID & ~RST;
  assign rd_elig = RD_VALID & rd_ok & ~RST;

  // Arbitration: a lone eligible requester wins; contention alternates with the previous winner
  always_comb begin
    gnt = GNT_NONE;
    if (wr_elig && rd_elig) begin
      gnt = (last_grant == GNT_WR) ? GNT_RD : GNT_WR;
    end else if (wr_elig) begin
      gnt = GNT_WR;
    end else if (rd_elig) begin
      gnt = GNT_RD;
    end
  end

`ifdef BRAM18_PORT_MASTER_PARITY_EN
  assign wr_dip  = byte_parity(WR_DATA[DATA_W-1:0]);
  assign PAR_ERR = rd_inflight & (byte_parity(RAM_DO) != RAM_DOP);
`else
  assign wr_dip  = WR_DATA[DATA_W +: PAR_W];
`endif

  // RAM address/data follow the granted request and otherwise hold, so idle cycles do not toggle the bus
  always_comb begin
    addr_nxt = addr_q;
    di_nxt   = di_q;
    dip_nxt  = dip_q;
    case (gnt)
      GNT_WR: begin
        addr_nxt = WR_ADDR;
        di_nxt   = WR_DATA[DATA_W-1:0];
        dip_nxt  = wr_dip;
      end
      GNT_RD: addr_nxt = RD_ADDR;
      default: ;
    endcase
  end

  assign WR_READY = (gnt == GNT_WR);
  assign RD_READY = (gnt == GNT_RD);
  assign RAM_EN   = (gnt != GNT_NONE);
  assign RAM_WE   = (gnt == GNT_WR);
  assign RAM_SSR  = 1'b0;
  assign RAM_ADDR = addr_nxt;
  assign RAM_DI   = di_nxt;
  assign RAM_DIP  = dip_nxt;

  // Grant history, read-in-flight flag and held RAM bus values
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_inflight <= 1'b0;
      last_grant  <= GNT_RD;
      addr_q      <= '0;
      di_q        <= '0;
      dip_q       <= '0;
    end else begin
      rd_inflight <= (gnt == GNT_RD);
      if (gnt != GNT_NONE) last_grant <= gnt;
      addr_q <= addr_nxt;
      di_q   <= di_nxt;
      dip_q  <= dip_nxt;
    end
  end

  // RAM output is valid the cycle after a read grant and is captured at the end of that cycle
  assign cap_dat = {RAM_DOP, RAM_DO};

  bram18_rsp_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (push),
    .push_dat (cap_dat),
    .pop      (pop),
    .pop_dat  (RSP_DATA),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign RSP_VALID = ~fifo_empty;

  // The credit limit must keep a capture from ever landing in a full FIFO
  a_no_push_when_full: assert property (@(posedge CLK) disable iff (RST) !(push && fifo_full));

endmodule
